// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fsm_fa_bit.sv
// One-bit combinational full adder cell.
// Ports: x, y, ci - addend bits and carry-in; s - sum bit; co - carry-out.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, one bit per
// clock LSB first. Operands are captured on an accepted start, the parallel sum
// and final carry are presented with a one-cycle done pulse.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - launch request, accepted in IDLE or DONE only
//   a, b, cin    - operands and carry-in, captured on accept
//   busy         - high while bits are being processed
//   done         - one-cycle pulse, sum/cout valid
//   sum, cout    - result register and final carry-out
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_carry_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_s;
  logic             w_co;

  // Single adder cell fed from the operand LSBs and the carry flop.
  fa_bit u_fa (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a_sh;
    w_b_nxt     = r_b_sh;
    w_sum_nxt   = r_sum;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;
    w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    case (r_state)
      S_IDLE: w_state_nxt = S_IDLE;
      S_SHIFT: begin
        w_sum_nxt   = {w_s, r_sum[WIDTH-1:1]};
        w_a_nxt     = r_a_sh >> 1;
        w_b_nxt     = r_b_sh >> 1;
        w_carry_nxt = w_co;
        // Hold the counter on the last bit so it never wraps.
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Accept overrides the idle/done fall-through and reloads the datapath.
    if (w_accept) begin
      w_state_nxt = S_SHIFT;
      w_a_nxt     = a;
      w_b_nxt     = b;
      w_carry_nxt = cin;
      w_cnt_nxt   = '0;
    end
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a_sh  <= w_a_nxt;
      r_b_sh  <= w_b_nxt;
      r_sum   <= w_sum_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_SHIFT);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm at WIDTH=8: directed vector table,
// multi-cycle corner sequences and a random sweep against plain addition.
module tb_serial_adder_fsm;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total;
  int bad;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Present operands with start at a falling edge; returns at the first busy cycle.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input bit keep_start);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    cin   = tc;
    @(negedge clk);
    if (!keep_start) start = 1'b0;
  endtask

  // Count remaining busy cycles until done, bounded.
  task automatic wait_done(output int nbusy, output bit ovl);
    nbusy = 0;
    ovl   = 1'b0;
    for (int n = 0; n < 40 && done !== 1'b1; n++) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    ovl = (busy === 1'b1) && (done === 1'b1);
  endtask

  task automatic finish_op(input string name, input logic [W-1:0] es, input logic ec,
                           input int exp_busy, input bit chk_pulse);
    int nb;
    bit ov;
    wait_done(nb, ov);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busycyc"}, 32'(nb), 32'(exp_busy));
    check({name, "_overlap"}, 32'(ov), 32'd0);
    check({name, "_result"}, 32'({cout, sum}), 32'({ec, es}));
    if (chk_pulse) begin
      @(negedge clk);
      check({name, "_pulse"}, 32'(done), 32'd0);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int        nb;
    bit        ov;
    logic [W:0] ref_v;
    logic [W-1:0] ra, rb;
    logic rc;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h01, 8'h7F, 1'b1, 8'h81, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].va, vecs[i].vb, vecs[i].vcin, 1'b0);
      finish_op($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout, int'(W), 1'b1);
    end

    // Operand changes while busy are ignored.
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    finish_op("midchg", 8'h46, 1'b0, int'(W) - 3, 1'b1);

    // A start pulse during SHIFT neither restarts nor delays the operation.
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("ignstart", 8'h30, 1'b0, int'(W) - 2, 1'b1);

    // Start held across done relaunches with no idle cycle.
    launch(8'h01, 8'h02, 1'b0, 1'b1);
    finish_op("hold1", 8'h03, 1'b0, int'(W), 1'b0);
    a = 8'h03; b = 8'h04; cin = 1'b0;
    @(negedge clk);
    check("hold_relaunch_busy", 32'(busy), 32'd1);
    check("hold_relaunch_done", 32'(done), 32'd0);
    start = 1'b0;
    finish_op("hold2", 8'h07, 1'b0, int'(W), 1'b1);

    // Reset at busy cycle 4 aborts immediately with no done pulse.
    launch(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    begin
      bit seen_done;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (i == 2) rst_n = 1'b1;
        if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      end
      check("abort_no_activity", 32'(seen_done), 32'd0);
    end
    launch(8'h3C, 8'hC3, 1'b1, 1'b0);
    finish_op("post_abort", 8'h00, 1'b1, int'(W), 1'b1);

    // Random sweep against plain addition.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      ref_v = (W + 1)'(ra) + (W + 1)'(rb) + (W + 1)'(rc);
      launch(ra, rb, rc, 1'b0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      wait_done(nb, ov);
      check("rnd_done", 32'(done), 32'd1);
      check("rnd_busycyc", 32'(nb), 32'(W));
      check("rnd_result", 32'({cout, sum}), 32'(ref_v));
      @(negedge clk);
      check("rnd_pulse", 32'(done), 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
